// File: rtl/clkgen_rst_seq_pkg.sv
// clkgen_rst_seq_pkg: state encodings, default timing constants and sizing helper
package clkgen_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_MMCM_RST  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_MMCM_RST_CYC     = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_RST_HOLD_CYC     = 16;
    localparam int DEF_MAX_RETRY        = 7;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchronizer bringing an asynchronous level into the clk domain
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // shift the input through the chain; rst clears it so the output starts low
    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/clkgen_rst_seq.sv
// clkgen_rst_seq: MMCM reset / lock supervisor that releases system reset after stable lock
module clkgen_rst_seq
    import clkgen_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int MMCM_RST_CYC     = DEF_MMCM_RST_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCKED_IN,
    input  logic       RETRY_REQ,
    output logic       MMCM_RESETN,
    output logic       SYS_RST,
    output logic       READY,
    output logic       FAIL,
    output logic [2:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam int CW = $clog2(max2(max2(MMCM_RST_CYC, LOCK_TIMEOUT_CYC),
                                    max2(LOCK_STABLE_CYC, RST_HOLD_CYC))) + 1;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    retry_n;
    logic [7:0]    loss_n;
    logic          locked_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(CLK),
        .rst(RST),
        .d  (LOCKED_IN),
        .q  (locked_s)
    );

    // next state and counter updates; a lost lock always beats a terminal count
    always_comb begin
        nxt     = state;
        retry_n = RETRY_CNT;
        loss_n  = LOSS_CNT;
        case (state)
            S_MMCM_RST:  if (cnt == CW'(MMCM_RST_CYC - 1)) nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (locked_s) nxt = S_STABLE;
                else if (cnt == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                    retry_n = (RETRY_CNT == 3'd7) ? RETRY_CNT : RETRY_CNT + 3'd1;
                    nxt     = (retry_n == 3'(MAX_RETRY)) ? S_FAIL : S_MMCM_RST;
                end
            end
            S_STABLE:    nxt = !locked_s ? S_WAIT_LOCK :
                               (cnt == CW'(LOCK_STABLE_CYC - 1)) ? S_HOLD : S_STABLE;
            S_HOLD:      nxt = !locked_s ? S_WAIT_LOCK :
                               (cnt == CW'(RST_HOLD_CYC - 1)) ? S_RUN : S_HOLD;
            S_RUN: begin
                if (!locked_s) begin
                    nxt    = S_MMCM_RST;
                    loss_n = (LOSS_CNT == 8'hff) ? LOSS_CNT : LOSS_CNT + 8'd1;
                end
            end
            S_FAIL: begin
                if (RETRY_REQ) begin
                    nxt     = S_MMCM_RST;
                    retry_n = 3'd0;
                end
            end
            default:     nxt = S_MMCM_RST;
        endcase
        if (nxt == S_RUN && state != S_RUN) retry_n = 3'd0;
    end

    // state, shared counter and outputs all registered from the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_MMCM_RST;
            cnt         <= '0;
            MMCM_RESETN <= 1'b0;
            SYS_RST     <= 1'b1;
            READY       <= 1'b0;
            FAIL        <= 1'b0;
            RETRY_CNT   <= 3'd0;
            LOSS_CNT    <= 8'd0;
        end else begin
            state       <= nxt;
            cnt         <= (nxt != state) ? '0 : cnt + 1'b1;
            MMCM_RESETN <= nxt != S_MMCM_RST;
            SYS_RST     <= nxt != S_RUN;
            READY       <= nxt == S_RUN;
            FAIL        <= nxt == S_FAIL;
            RETRY_CNT   <= retry_n;
            LOSS_CNT    <= loss_n;
        end
    end

endmodule

// File: tb/tb_clkgen_rst_seq.sv
// tb_clkgen_rst_seq: vector table plus directed sequences for the MMCM reset sequencer
module tb_clkgen_rst_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       LOCKED_IN = 1'b0;
    logic       RETRY_REQ = 1'b0;
    logic       MMCM_RESETN, SYS_RST, READY, FAIL;
    logic [2:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    clkgen_rst_seq #(
        .SYNC_STAGES     (2),
        .MMCM_RST_CYC    (4),
        .LOCK_TIMEOUT_CYC(20),
        .LOCK_STABLE_CYC (8),
        .RST_HOLD_CYC    (4),
        .MAX_RETRY       (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LOCKED_IN  (LOCKED_IN),
        .RETRY_REQ  (RETRY_REQ),
        .MMCM_RESETN(MMCM_RESETN),
        .SYS_RST    (SYS_RST),
        .READY      (READY),
        .FAIL       (FAIL),
        .RETRY_CNT  (RETRY_CNT),
        .LOSS_CNT   (LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         at;
        logic       locked;
        logic       req;
        logic       rn;
        logic       sr;
        logic       rdy;
        logic       fl;
        logic [2:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int at, input logic lk, input logic rq, input logic rn,
                                input logic sr, input logic rdy, input logic fl,
                                input logic [2:0] rc, input logic [7:0] lc);
        vec_t v;
        v.at = at; v.locked = lk; v.req = rq; v.rn = rn; v.sr = sr;
        v.rdy = rdy; v.fl = fl; v.rc = rc; v.lc = lc;
        return v;
    endfunction

    // cycle N is the interval after the Nth edge following the reset edge
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic lk);
        RST = 1'b1;
        LOCKED_IN = lk;
        RETRY_REQ = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({MMCM_RESETN, SYS_RST, READY, FAIL, RETRY_CNT, LOSS_CNT});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // normal bring-up with lock present from reset: RUN at cycle 4+1+8+4 = 17
        tbl.push_back(mk(0,   1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(3,   1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4,   1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(16,  1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(17,  1, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(30,  1, 0, 1, 0, 1, 0, 0, 0));
        // lock never arrives: attempts of 4+20 cycles, FAIL at 72; RETRY_REQ in WAIT_LOCK ignored
        tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4,   0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(10,  0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(11,  0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(23,  0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(24,  0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(27,  0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(28,  0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(48,  0, 0, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(52,  0, 0, 1, 1, 0, 0, 2, 0));
        tbl.push_back(mk(71,  0, 0, 1, 1, 0, 0, 2, 0));
        tbl.push_back(mk(72,  0, 0, 1, 1, 0, 1, 3, 0));
        tbl.push_back(mk(100, 1, 1, 1, 1, 0, 1, 3, 0));
        tbl.push_back(mk(101, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(104, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(105, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(117, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(118, 1, 0, 1, 0, 1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].at == 0) do_reset(tbl[i].locked);
            while (cyc < tbl[i].at) tick();
            chk($sformatf("vec%0d", i), outs(),
                32'({tbl[i].rn, tbl[i].sr, tbl[i].rdy, tbl[i].fl, tbl[i].rc, tbl[i].lc}));
            LOCKED_IN = tbl[i].locked;
            RETRY_REQ = tbl[i].req;
        end
        RETRY_REQ = 1'b0;

        // glitch seen by the FSM on STABLE's terminal cycle (12): WAIT_LOCK at 13, RUN at 26
        do_reset(1'b1);
        while (cyc < 10) tick();
        LOCKED_IN = 1'b0;
        tick();
        LOCKED_IN = 1'b1;
        while (cyc < 13) tick();
        chk("glitch mmcm_resetn", 32'(MMCM_RESETN), 32'd1);
        while (cyc < 17) tick();
        chk("glitch not ready at 17", 32'(READY), 32'd0);
        while (cyc < 25) tick();
        chk("glitch ready at 25", 32'(READY), 32'd0);
        tick();
        chk("glitch ready at 26", 32'(READY), 32'd1);
        chk("glitch sys_rst at 26", 32'(SYS_RST), 32'd0);
        chk("glitch retry_cnt", 32'(RETRY_CNT), 32'd0);

        // RETRY_REQ in RUN changes nothing
        RETRY_REQ = 1'b1;
        tick();
        RETRY_REQ = 1'b0;
        chk("req in run a", outs(), 32'({4'b1010, 3'd0, 8'd0}));
        tick();
        chk("req in run b", outs(), 32'({4'b1010, 3'd0, 8'd0}));

        // repeated lock loss in RUN: SYS_RST at drop+3 edges, re-bring-up of 17 cycles
        for (int i = 0; i < 300; i++) begin
            LOCKED_IN = 1'b0;
            tick();
            tick();
            chk("loss sys_rst before", 32'(SYS_RST), 32'd0);
            tick();
            chk("loss sys_rst", 32'(SYS_RST), 32'd1);
            chk("loss mmcm_resetn", 32'(MMCM_RESETN), 32'd0);
            chk("loss cnt", 32'(LOSS_CNT), (i >= 254) ? 32'd255 : 32'(i + 1));
            LOCKED_IN = 1'b1;
            n = 0;
            if (i == 0) begin
                tick(); tick(); tick();
                chk("loss mmcm_resetn 4th", 32'(MMCM_RESETN), 32'd0);
                tick();
                chk("loss mmcm_resetn release", 32'(MMCM_RESETN), 32'd1);
                n = 4;
            end
            while (!READY && n < 100) begin
                tick();
                n++;
            end
            chk("relock cycles", 32'(n), 32'd17);
        end
        chk("loss cnt final", 32'(LOSS_CNT), 32'd255);

        // RST pulse in HOLD returns every output to reset values, then a full restart
        LOCKED_IN = 1'b0;
        tick(); tick(); tick();
        chk("loss cnt saturated", 32'(LOSS_CNT), 32'd255);
        LOCKED_IN = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("in hold", outs(), 32'({4'b1100, 3'd0, 8'd255}));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        cyc = 0;
        chk("rst mid hold", outs(), 32'({4'b0100, 3'd0, 8'd0}));
        while (cyc < 16) tick();
        chk("restart ready at 16", 32'(READY), 32'd0);
        tick();
        chk("restart ready at 17", 32'(READY), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
